hazard_ctrl_seq: RTL and testbench
==================================

// Module: hazard_ctrl_seq
// PURPOSE
// Sequential hazard controller for the 5-stage pipeline: EX forwarding selects, load-use bubbles, control flushes and cache-miss freezes.
// Supports loads whose data arrives LU_STALL_CYC cycles late, a miss-wait FSM with a watchdog, and saturating stall/flush performance counters.
// Sits beside the datapath and drives F/D/E stall and flush enables; consumes miss/ready status from the memory controller.
// PARAMETERS
// REG_AW        5    register-address width (x0 is never forwarded or hazarded)
// LU_STALL_CYC  1    bubbles inserted per load-use hazard (1..7)
// WDOG_CYC      255  MISS_WAIT cycles before mem_timeout is raised
// CNT_W         32   performance-counter width
// PORTS
// clk            in   1       clock
// rst            in   1       synchronous active-high reset
// rs1_d,rs2_d    in   REG_AW  source regs in Decode
// rs1_e,rs2_e    in   REG_AW  source regs in Execute
// rd_e           in   REG_AW  dest reg in Execute
// mem_read_e     in   1       Execute instruction is a load
// rd_m,rd_w      in   REG_AW  dest regs in Memory / Writeback
// reg_write_m    in   1       Memory stage writes rd_m
// reg_write_w    in   1       Writeback stage writes rd_w
// branch_taken_e in   1       taken branch resolved in Execute
// jump_e         in   1       jump resolved in Execute
// mem_miss       in   1       L1/L2 miss or cache busy on the current Memory access
// mem_ready      in   1       refill complete, data valid this cycle
// fwd_a_e        out  2       00 regfile, 10 from M, 01 from W
// fwd_b_e        out  2       same encoding for operand B
// stall_f        out  1       hold PC
// stall_d        out  1       hold IF/ID
// stall_e        out  1       hold ID/EX and EX/MEM (miss freeze only)
// flush_d        out  1       zero IF/ID
// flush_e        out  1       zero ID/EX (bubble)
// mem_timeout    out  1       sticky watchdog error
// cnt_lu,cnt_miss,cnt_ctrl out CNT_W  load-use bubbles, miss-freeze cycles, control flushes
// BEHAVIOUR
// Reset: FSM=RUN, internal counters 0, all outputs 0 (fwd=00, mem_timeout=0, cnt_*=0).
// Forwarding (combinational, every state):
// - M wins over W.
// - Never forward when the matching reg is 0 or its reg_write is 0.
// FSM states RUN, LU_STALL, MISS_WAIT. Priority each cycle: miss > control > load-use.
// - RUN, mem_miss=1: go to MISS_WAIT.
//   - stall_f/d/e=1 and flush_*=0 in the same cycle; the pipeline freezes, EX state included.
// - RUN, branch_taken_e|jump_e: flush_d=flush_e=1, stall_*=0, cnt_ctrl++.
//   - A load-use hazard in the same cycle is discarded.
// - RUN, load-use (mem_read_e, rd_e!=0, rd_e==rs1_d|rs2_d): stall_f=stall_d=1 and flush_e=1.
//   - Set lu_cnt=LU_STALL_CYC-1, then go to LU_STALL, or stay in RUN if lu_cnt==0.
//   - cnt_lu++ on every bubble cycle.
// - LU_STALL: same outputs, lu_cnt--. Exit to RUN when lu_cnt==0.
//   - mem_miss here preempts to MISS_WAIT and the remaining bubbles are dropped.
// - MISS_WAIT: stall_f/d/e=1 and cnt_miss++ every cycle; wd_cnt increments.
//   - On mem_ready, go to RUN the next cycle; stalls drop in that RUN cycle.
//   - A branch held in EX is flushed in that first RUN cycle, because EX was frozen.
//   - If wd_cnt reaches WDOG_CYC, set mem_timeout=1. It stays set until rst. The FSM keeps waiting.
// - mem_ready with no miss pending: ignored.
// - mem_miss and mem_ready both high in MISS_WAIT: exit (ready wins).
// - Counters saturate at all-ones and never wrap. wd_cnt clears on entry to MISS_WAIT.
// - rst in any state, mid-stall or mid-miss, returns to RUN next edge with all counters cleared.
// STRUCTURE
// Package hazard_pkg:
// - typedef hz_state_e {RUN, LU_STALL, MISS_WAIT}.
// - fwd_sel_e constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
// One sub-module: hz_sat_counter #(CNT_W), instantiated three times for cnt_lu, cnt_miss and cnt_ctrl.
// Forwarding logic stays inline.
// TESTING
// T1 fwd:
// - rd_m=rd_w=5, both reg_write=1, rs1_e=5 -> fwd_a_e=10.
// - reg_write_m=0 -> fwd_a_e=01.
// - rs1_e=0 -> fwd_a_e=00.
// T2 load-use, LU_STALL_CYC=2: mem_read_e=1, rd_e=7, rs2_d=7 -> stall_f/d=1 and flush_e=1 for exactly 2 cycles; cnt_lu=2.
// T3 ctrl+lu same cycle: branch_taken_e=1 with load-use active -> flush_d/e=1 and stall_f/d=0 for 1 cycle; cnt_ctrl=1, cnt_lu=0.
// T4 miss: mem_miss pulse then mem_ready after 10 cycles -> stall_f/d/e=1 for 11 cycles; cnt_miss=11; flush_* stay 0.
// T5 watchdog, WDOG_CYC=4: miss with no ready -> mem_timeout=1 after 4 cycles; a later mem_ready returns to RUN and mem_timeout stays 1.
// T6 reset mid-MISS_WAIT and counter saturation with CNT_W=3 -> all outputs 0 next cycle; a counter driven past 7 holds at 7.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      LU_STALL  = 2'd1,
      MISS_WAIT = 2'd2
   } hz_state_e;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module hz_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   // next count: increment unless already saturated
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   // count register
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl_seq.sv
// Hazard controller for the 5-stage pipeline: EX forwarding, load-use
// bubbles, control flushes and cache-miss freezes with a watchdog.
//
// state     | meaning
// ----------+-------------------------------------------------------
// RUN       | normal issue; evaluates miss > control > load-use
// LU_STALL  | extra load-use bubbles still owed (lu_cnt of them)
// MISS_WAIT | whole front end and EX frozen until mem_ready
module hazard_ctrl_seq
   import hazard_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter int LU_STALL_CYC = 1,
   parameter int WDOG_CYC     = 255,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              mem_read_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   input  logic              branch_taken_e,
   input  logic              jump_e,
   input  logic              mem_miss,
   input  logic              mem_ready,
   output logic [1:0]        fwd_a_e,
   output logic [1:0]        fwd_b_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              flush_d,
   output logic              flush_e,
   output logic              mem_timeout,
   output logic [CNT_W-1:0]  cnt_lu,
   output logic [CNT_W-1:0]  cnt_miss,
   output logic [CNT_W-1:0]  cnt_ctrl
);

   localparam int             WD_W    = $clog2(WDOG_CYC + 1);
   localparam logic [WD_W-1:0] WDOG_TC = WD_W'(WDOG_CYC);
   localparam logic [2:0]      LU_INIT = 3'(LU_STALL_CYC - 1);

   hz_state_e       state_d, state_q;
   logic [2:0]      lu_cnt_d, lu_cnt_q;
   logic [WD_W-1:0] wd_cnt_d, wd_cnt_q;
   logic            timeout_d, timeout_q;
   logic            lu_hazard, ctrl_redirect;
   logic            inc_lu, inc_miss, inc_ctrl;

   // operand forwarding: M has the younger value so it overrides W
   always_comb begin
      fwd_a_e = FWD_RF;
      fwd_b_e = FWD_RF;
      if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) fwd_a_e = FWD_W;
      if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e)) fwd_a_e = FWD_M;
      if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) fwd_b_e = FWD_W;
      if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e)) fwd_b_e = FWD_M;
   end

   assign lu_hazard     = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
   assign ctrl_redirect = branch_taken_e | jump_e;

   // sequencing FSM: stall/flush enables, bubble and watchdog counters
   always_comb begin
      state_d   = state_q;
      lu_cnt_d  = lu_cnt_q;
      wd_cnt_d  = wd_cnt_q;
      timeout_d = timeout_q;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      inc_lu    = 1'b0;
      inc_miss  = 1'b0;
      inc_ctrl  = 1'b0;
      case (state_q)
         RUN, LU_STALL: begin
            if (mem_miss) begin
               {stall_f, stall_d, stall_e} = 3'b111;
               inc_miss = 1'b1;
               wd_cnt_d = '0;
               lu_cnt_d = '0;
               state_d  = MISS_WAIT;
            end else if (ctrl_redirect) begin
               // a bubble requested alongside a redirect is moot: the load's
               // consumer is being flushed anyway
               flush_d  = 1'b1;
               flush_e  = 1'b1;
               inc_ctrl = 1'b1;
               lu_cnt_d = '0;
               state_d  = RUN;
            end else if (state_q == LU_STALL) begin
               {stall_f, stall_d, flush_e} = 3'b111;
               inc_lu   = 1'b1;
               lu_cnt_d = lu_cnt_q - 3'd1;
               if (lu_cnt_d == 3'd0) state_d = RUN;
            end else if (lu_hazard) begin
               {stall_f, stall_d, flush_e} = 3'b111;
               inc_lu   = 1'b1;
               lu_cnt_d = LU_INIT;
               if (LU_INIT != 3'd0) state_d = LU_STALL;
            end
         end
         MISS_WAIT: begin
            {stall_f, stall_d, stall_e} = 3'b111;
            inc_miss = 1'b1;
            if (wd_cnt_q != WDOG_TC) wd_cnt_d = wd_cnt_q + 1'b1;
            if (wd_cnt_d == WDOG_TC) timeout_d = 1'b1;
            if (mem_ready) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         lu_cnt_q  <= '0;
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lu_cnt_q  <= lu_cnt_d;
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign mem_timeout = timeout_q;

   hz_sat_counter #(.CNT_W(CNT_W)) u_cnt_lu   (.clk(clk), .rst(rst), .inc(inc_lu),   .cnt(cnt_lu));
   hz_sat_counter #(.CNT_W(CNT_W)) u_cnt_miss (.clk(clk), .rst(rst), .inc(inc_miss), .cnt(cnt_miss));
   hz_sat_counter #(.CNT_W(CNT_W)) u_cnt_ctrl (.clk(clk), .rst(rst), .inc(inc_ctrl), .cnt(cnt_ctrl));

endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// Bench for hazard_ctrl_seq: directed scenarios plus randomized traffic
// against a cycle-level behavioural model. Two instances share inputs and
// differ only in counter width (3 bits to hit saturation, 8 bits for counts).
module tb_hazard_ctrl_seq;

   localparam int LU   = 2;
   localparam int WDOG = 4;

   logic       clk, rst;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       mem_read_e, reg_write_m, reg_write_w, branch_taken_e, jump_e;
   logic       mem_miss, mem_ready;

   logic [1:0] fwd_a_e, fwd_b_e, fwd_a_w, fwd_b_w;
   logic       stall_f, stall_d, stall_e, flush_d, flush_e, mem_timeout;
   logic       stall_f_w, stall_d_w, stall_e_w, flush_d_w, flush_e_w, mem_timeout_w;
   logic [2:0] cnt_lu, cnt_miss, cnt_ctrl;
   logic [7:0] cnt_lu_w, cnt_miss_w, cnt_ctrl_w;

   hazard_ctrl_seq #(.REG_AW(5), .LU_STALL_CYC(LU), .WDOG_CYC(WDOG), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .mem_read_e(mem_read_e), .rd_m(rd_m), .rd_w(rd_w),
      .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .branch_taken_e(branch_taken_e),
      .jump_e(jump_e), .mem_miss(mem_miss), .mem_ready(mem_ready),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_f(stall_f), .stall_d(stall_d),
      .stall_e(stall_e), .flush_d(flush_d), .flush_e(flush_e), .mem_timeout(mem_timeout),
      .cnt_lu(cnt_lu), .cnt_miss(cnt_miss), .cnt_ctrl(cnt_ctrl));

   hazard_ctrl_seq #(.REG_AW(5), .LU_STALL_CYC(LU), .WDOG_CYC(WDOG), .CNT_W(8)) dut_w (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .mem_read_e(mem_read_e), .rd_m(rd_m), .rd_w(rd_w),
      .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .branch_taken_e(branch_taken_e),
      .jump_e(jump_e), .mem_miss(mem_miss), .mem_ready(mem_ready),
      .fwd_a_e(fwd_a_w), .fwd_b_e(fwd_b_w), .stall_f(stall_f_w), .stall_d(stall_d_w),
      .stall_e(stall_e_w), .flush_d(flush_d_w), .flush_e(flush_e_w), .mem_timeout(mem_timeout_w),
      .cnt_lu(cnt_lu_w), .cnt_miss(cnt_miss_w), .cnt_ctrl(cnt_ctrl_w));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_in_miss;     // waiting for a refill
   int m_bub_left;    // load-use bubbles still owed after this cycle
   int m_wait;        // cycles spent waiting in the current miss
   bit m_to;
   int c_lu, c_miss, c_ctrl;  // unbounded event counts

   function automatic logic [1:0] fwd_model(input logic [4:0] rs);
      if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
      if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit lu_model();
      return mem_read_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
   endfunction

   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   // 0 = none, 1 = freeze, 2 = redirect flush, 3 = bubble
   function automatic int action();
      if (m_in_miss || mem_miss) return 1;
      if (branch_taken_e || jump_e) return 2;
      if (m_bub_left > 0 || lu_model()) return 3;
      return 0;
   endfunction

   task automatic model_compare();
      int  a;
      a = action();
      check("fwd_a",   fwd_a_e, fwd_model(rs1_e));
      check("fwd_b",   fwd_b_e, fwd_model(rs2_e));
      check("stall_f", stall_f, (a == 1 || a == 3));
      check("stall_d", stall_d, (a == 1 || a == 3));
      check("stall_e", stall_e, (a == 1));
      check("flush_d", flush_d, (a == 2));
      check("flush_e", flush_e, (a == 2 || a == 3));
      check("timeout", mem_timeout, m_to);
      check("timeout_w", mem_timeout_w, m_to);
      check("cnt_lu",   cnt_lu,   sat(c_lu, 7));
      check("cnt_miss", cnt_miss, sat(c_miss, 7));
      check("cnt_ctrl", cnt_ctrl, sat(c_ctrl, 7));
      check("cnt_lu_w",   cnt_lu_w,   sat(c_lu, 255));
      check("cnt_miss_w", cnt_miss_w, sat(c_miss, 255));
      check("cnt_ctrl_w", cnt_ctrl_w, sat(c_ctrl, 255));
   endtask

   task automatic model_update();
      int a;
      if (rst) begin
         m_in_miss = 0; m_bub_left = 0; m_wait = 0; m_to = 0;
         c_lu = 0; c_miss = 0; c_ctrl = 0;
         return;
      end
      a = action();
      if (m_in_miss) begin
         c_miss++;
         if (m_wait < WDOG) m_wait++;
         if (m_wait == WDOG) m_to = 1;
         if (mem_ready) m_in_miss = 0;
      end else if (a == 1) begin
         c_miss++;
         m_in_miss = 1; m_wait = 0; m_bub_left = 0;
      end else if (a == 2) begin
         c_ctrl++;
         m_bub_left = 0;
      end else if (a == 3) begin
         c_lu++;
         if (m_bub_left > 0) m_bub_left--;
         else                m_bub_left = LU - 1;
      end
   endtask

   // one clock: compare at the falling edge, advance the model at the rising edge
   task automatic cycle();
      @(negedge clk);
      if (!rst) model_compare();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
      {mem_read_e, reg_write_m, reg_write_w, branch_taken_e, jump_e, mem_miss, mem_ready} = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      #1;
   endtask

   int n_stall, n_flush;

   initial begin
      idle();
      rst = 1'b1;
      #1;
      do_reset();

      // reset state
      check("rst_stall_f", stall_f, 0);
      check("rst_flush_e", flush_e, 0);
      check("rst_fwd_a", fwd_a_e, 0);
      check("rst_timeout", mem_timeout, 0);
      check("rst_cnt_lu", cnt_lu_w, 0);

      // T1 forwarding
      rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1; rs1_e = 5; rs2_e = 5; #1;
      check("t1_fwd_m", fwd_a_e, 2'b10);
      check("t1_fwd_b_m", fwd_b_e, 2'b10);
      reg_write_m = 0; #1;
      check("t1_fwd_w", fwd_a_e, 2'b01);
      rs1_e = 0; #1;
      check("t1_fwd_x0", fwd_a_e, 2'b00);
      rd_w = 0; rs2_e = 0; #1;
      check("t1_fwd_rd0", fwd_b_e, 2'b00);
      cycle();

      // T2 load-use, two bubbles
      do_reset();
      mem_read_e = 1; rd_e = 7; rs2_d = 7; #1;
      check("t2_b1_stall_f", stall_f, 1);
      check("t2_b1_flush_e", flush_e, 1);
      check("t2_b1_stall_e", stall_e, 0);
      cycle();
      idle(); #1;
      check("t2_b2_stall_d", stall_d, 1);
      check("t2_b2_flush_e", flush_e, 1);
      cycle();
      check("t2_end_stall_f", stall_f, 0);
      check("t2_cnt_lu", cnt_lu_w, 2);

      // T3 redirect beats load-use
      do_reset();
      mem_read_e = 1; rd_e = 3; rs1_d = 3; branch_taken_e = 1; #1;
      check("t3_flush_d", flush_d, 1);
      check("t3_flush_e", flush_e, 1);
      check("t3_stall_f", stall_f, 0);
      cycle();
      idle(); #1;
      check("t3_after_flush_d", flush_d, 0);
      check("t3_cnt_ctrl", cnt_ctrl_w, 1);
      check("t3_cnt_lu", cnt_lu_w, 0);

      // T4 miss freeze, ready ten cycles after the miss
      do_reset();
      n_stall = 0; n_flush = 0;
      mem_miss = 1; #1;
      n_stall += stall_e; n_flush += flush_d | flush_e;
      cycle();
      mem_miss = 0;
      for (int i = 0; i < 9; i++) begin
         n_stall += stall_e; n_flush += flush_d | flush_e;
         cycle();
      end
      mem_ready = 1; #1;
      n_stall += stall_e; n_flush += flush_d | flush_e;
      cycle();
      mem_ready = 0; #1;
      check("t4_stall_done", stall_e, 0);
      check("t4_stall_cycles", n_stall, 11);
      check("t4_flushes", n_flush, 0);
      check("t4_cnt_miss", cnt_miss_w, 11);
      check("t6_sat_cnt_miss", cnt_miss, 7);
      mem_ready = 1; #1;
      check("t4_stray_ready", stall_f, 0);
      cycle();
      idle();

      // T5 watchdog
      do_reset();
      mem_miss = 1;
      cycle();
      mem_miss = 0;
      for (int i = 0; i < WDOG; i++) begin
         check("t5_pre_timeout", mem_timeout, 0);
         cycle();
      end
      check("t5_timeout", mem_timeout, 1);
      check("t5_still_stall", stall_f, 1);
      cycle();
      mem_ready = 1;
      cycle();
      mem_ready = 0; #1;
      check("t5_run_stall", stall_f, 0);
      check("t5_sticky", mem_timeout, 1);
      cycle();
      check("t5_sticky2", mem_timeout, 1);

      // T6 reset mid-miss
      do_reset();
      mem_miss = 1;
      cycle();
      mem_miss = 0;
      cycle();
      cycle();
      rst = 1;
      cycle();
      rst = 0; #1;
      check("t6_stall_e", stall_e, 0);
      check("t6_stall_f", stall_f, 0);
      check("t6_cnt_miss", cnt_miss, 0);
      check("t6_timeout", mem_timeout, 0);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         rst            = ($urandom_range(0, 149) == 0);
         rs1_d          = 5'($urandom_range(0, 7));
         rs2_d          = 5'($urandom_range(0, 7));
         rs1_e          = 5'($urandom_range(0, 7));
         rs2_e          = 5'($urandom_range(0, 7));
         rd_e           = 5'($urandom_range(0, 7));
         rd_m           = 5'($urandom_range(0, 7));
         rd_w           = 5'($urandom_range(0, 7));
         mem_read_e     = 1'($urandom_range(0, 1));
         reg_write_m    = 1'($urandom_range(0, 1));
         reg_write_w    = 1'($urandom_range(0, 1));
         branch_taken_e = ($urandom_range(0, 7) == 0);
         jump_e         = ($urandom_range(0, 11) == 0);
         mem_miss       = ($urandom_range(0, 11) == 0);
         mem_ready      = ($urandom_range(0, 4) == 0);
         cycle();
      end
      rst = 0;
      idle();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
